// File: rtl/user_gpio_in_conditioner.sv
// Input conditioner for the user io_in pads: 2-flop sync, tick-based debounce, edge status
// with W1C clear, level interrupt and a small Wishbone register window.
module user_gpio_in_conditioner #(
  parameter int unsigned NPADS    = 38,
  parameter logic [31:0] BASE_ADR = 32'h300F_FFC0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] gpio_in_deb,
  output logic             irq
);

  localparam int unsigned HiW = NPADS - 32;

  localparam logic [2:0] IdxInL   = 3'd0;
  localparam logic [2:0] IdxInH   = 3'd1;
  localparam logic [2:0] IdxCtrl  = 3'd2;
  localparam logic [2:0] IdxIenL  = 3'd3;
  localparam logic [2:0] IdxIenH  = 3'd4;
  localparam logic [2:0] IdxStatL = 3'd5;
  localparam logic [2:0] IdxStatH = 3'd6;

  // State
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             rise_en_q, rise_en_d;
  logic             fall_en_q, fall_en_d;
  logic             bypass_q, bypass_d;
  logic [7:0]       div_q, div_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NPADS-1:0] s1_q, s2_q;
  logic [NPADS-1:0] h0_q, h0_d;
  logic [NPADS-1:0] h1_q, h1_d;
  logic [NPADS-1:0] deb_q, deb_d;
  logic [NPADS-1:0] ien_q, ien_d;
  logic [NPADS-1:0] stat_q, stat_d;

  // Bus decode
  logic [31:0] off;
  logic [2:0]  idx;
  logic        hit;
  logic        match;
  logic        wr;
  logic        rd;
  logic [31:0] be;
  logic [31:0] rdata;

  assign off   = wbs_adr_i - BASE_ADR;
  assign idx   = off[4:2];
  assign hit   = (off[31:5] == '0) && (off[1:0] == 2'b00) && (idx != 3'd7);
  assign match = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
  assign wr    = match & wbs_we_i;
  assign rd    = match & ~wbs_we_i;
  assign be    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // Input path signals
  logic             tick;
  logic             div_wr;
  logic [NPADS-1:0] stable;
  logic [NPADS-1:0] rise;
  logic [NPADS-1:0] fall;
  logic [NPADS-1:0] stat_set;
  logic [NPADS-1:0] stat_clr;

  assign tick   = (cnt_q == div_q);
  assign div_wr = wr && (idx == IdxCtrl) && wbs_sel_i[1];
  // A pin is stable when the current sample matches the two previous tick samples.
  assign stable = ~(s2_q ^ h0_q) & ~(s2_q ^ h1_q);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (div_wr || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    if (tick) begin
      h0_d = s2_q;
      h1_d = h0_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    if (bypass_q) begin
      deb_d = s2_q;
    end else if (tick) begin
      deb_d = (deb_q & ~stable) | (s2_q & stable);
    end
  end

  assign rise     = deb_d & ~deb_q;
  assign fall     = ~deb_d & deb_q;
  assign stat_set = ({NPADS{rise_en_q}} & rise) | ({NPADS{fall_en_q}} & fall);

  always_comb begin
    stat_clr = '0;
    if (wr && (idx == IdxStatL)) begin
      stat_clr[31:0] = wbs_dat_i & be;
    end
    if (wr && (idx == IdxStatH)) begin
      stat_clr[NPADS-1:32] = wbs_dat_i[HiW-1:0] & be[HiW-1:0];
    end
  end

  // A set on the same edge as a clear wins.
  assign stat_d = (stat_q & ~stat_clr) | stat_set;

  always_comb begin
    ien_d = ien_q;
    if (wr && (idx == IdxIenL)) begin
      ien_d[31:0] = (ien_q[31:0] & ~be) | (wbs_dat_i & be);
    end
    if (wr && (idx == IdxIenH)) begin
      ien_d[NPADS-1:32] = (ien_q[NPADS-1:32] & ~be[HiW-1:0]) | (wbs_dat_i[HiW-1:0] & be[HiW-1:0]);
    end
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    bypass_d  = bypass_q;
    div_d     = div_q;
    if (wr && (idx == IdxCtrl)) begin
      if (wbs_sel_i[0]) begin
        rise_en_d = wbs_dat_i[0];
        fall_en_d = wbs_dat_i[1];
        bypass_d  = wbs_dat_i[2];
      end
      if (wbs_sel_i[1]) begin
        div_d = wbs_dat_i[15:8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IdxInL:   rdata = deb_q[31:0];
      IdxInH:   rdata[HiW-1:0] = deb_q[NPADS-1:32];
      IdxCtrl:  rdata = {16'h0, div_q, 5'h0, bypass_q, fall_en_q, rise_en_q};
      IdxIenL:  rdata = ien_q[31:0];
      IdxIenH:  rdata[HiW-1:0] = ien_q[NPADS-1:32];
      IdxStatL: rdata = stat_q[31:0];
      IdxStatH: rdata[HiW-1:0] = stat_q[NPADS-1:32];
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = match;
    dat_d = rd ? rdata : 32'h0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      rise_en_q <= 1'b1;
      fall_en_q <= 1'b0;
      bypass_q  <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      deb_q     <= '0;
      ien_q     <= '0;
      stat_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      bypass_q  <= bypass_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      s1_q      <= io_in;
      s2_q      <= s1_q;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      deb_q     <= deb_d;
      ien_q     <= ien_d;
      stat_q    <= stat_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign gpio_in_deb = deb_q;
  assign irq         = |(stat_q & ien_q);

endmodule

// File: tb/tb_user_gpio_in_conditioner.sv
// Bench for user_gpio_in_conditioner: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the pad conditioner and register window.
module tb_user_gpio_in_conditioner;

  localparam int unsigned NPADS = 38;
  localparam logic [31:0] BASE  = 32'h300F_FFC0;
  localparam logic [63:0] PadMask = (64'd1 << NPADS) - 64'd1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]       sel = 4'h0;
  logic [31:0]      wdat = '0, adr = '0;
  logic             ack;
  logic [31:0]      rdat;
  logic [NPADS-1:0] io = '0;
  logic [NPADS-1:0] deb;
  logic             irq;

  user_gpio_in_conditioner #(.NPADS(NPADS), .BASE_ADR(BASE)) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rstn),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (wdat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .io_in       (io),
    .gpio_in_deb (deb),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_s1, m_s2, m_t0, m_t1, m_deb, m_stat, m_ien;
  logic        m_rise, m_fall, m_byp, m_ack;
  logic [7:0]  m_div, m_cnt;
  logic [31:0] m_dat;

  function automatic int reg_idx(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'd28 && a[1:0] == 2'b00) return int'((a - BASE) >> 2);
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input int i);
    case (i)
      0: return m_deb[31:0];
      1: return m_deb[63:32];
      2: return {16'h0, m_div, 5'h0, m_byp, m_fall, m_rise};
      3: return m_ien[31:0];
      4: return m_ien[63:32];
      5: return m_stat[31:0];
      6: return m_stat[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_t0 = '0; m_t1 = '0; m_deb = '0; m_stat = '0; m_ien = '0;
    m_rise = 1'b1; m_fall = 1'b0; m_byp = 1'b0; m_ack = 1'b0;
    m_div = '0; m_cnt = '0; m_dat = '0;
  endtask

  task automatic model_step();
    int          i;
    bit          match, wrm, tick;
    logic [31:0] bm;
    logic [63:0] nd, setv, clr;
    i     = reg_idx(adr);
    match = cyc && stb && !m_ack && (i >= 0);
    wrm   = match && we;
    bm    = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    tick  = (m_cnt == m_div);
    // Debounced value: follows the sync output when bypassed; otherwise takes it only when
    // the last three tick samples agree.
    nd = m_deb;
    if (m_byp) nd = m_s2;
    else if (tick)
      for (int p = 0; p < NPADS; p++)
        if (m_s2[p] == m_t0[p] && m_t0[p] == m_t1[p]) nd[p] = m_s2[p];
    setv = ((m_rise ? (nd & ~m_deb) : 64'h0) | (m_fall ? (~nd & m_deb) : 64'h0)) & PadMask;
    clr = '0;
    if (wrm && i == 5) clr[31:0]  = wdat & bm;
    if (wrm && i == 6) clr[63:32] = wdat & bm;
    clr &= PadMask;
    m_dat = (match && !we) ? m_read(i) : 32'h0;
    m_ack = match;
    if (wrm && i == 2) begin
      if (sel[0]) begin m_rise = wdat[0]; m_fall = wdat[1]; m_byp = wdat[2]; end
      if (sel[1]) m_div = wdat[15:8];
    end
    if (wrm && i == 3) m_ien[31:0]  = (m_ien[31:0] & ~bm) | (wdat & bm);
    if (wrm && i == 4) m_ien[63:32] = (m_ien[63:32] & ~bm) | (wdat & bm);
    m_ien &= PadMask;
    m_stat = (m_stat & ~clr) | setv;
    m_deb  = nd;
    if ((wrm && i == 2 && sel[1]) || tick) m_cnt = '0;
    else m_cnt = m_cnt + 8'd1;
    if (tick) begin m_t1 = m_t0; m_t0 = m_s2; end
    m_s2 = m_s1;
    m_s1 = 64'(io);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rstn && mon_on) begin
      check_eq("ack", 64'(ack), 64'(m_ack));
      check_eq("dat_o", 64'(rdat), 64'(m_dat));
      check_eq("deb", 64'(deb), m_deb);
      check_eq("irq", 64'(irq), 64'(|(m_stat & m_ien)));
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output bit ok);
    ok = 1'b0; r = '0;
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) begin ok = 1'b1; r = rdat; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] r;
    bit          ok;
    wb_xfer(a, 1'b1, d, s, r, ok);
    check_eq({tag, "_ack"}, 64'(ok), 64'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bit          ok;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, r, ok);
    check_eq({tag, "_ack"}, 64'(ok), 64'd1);
    check_eq(tag, 64'(r), 64'(exp));
  endtask

  task automatic reset_reads(input string pfx);
    logic [31:0] r;
    bit          ok;
    wb_read({pfx, "in_l"},   BASE + 32'h00, 32'h0);
    wb_read({pfx, "in_h"},   BASE + 32'h04, 32'h0);
    wb_read({pfx, "ctrl"},   BASE + 32'h08, 32'h1);
    wb_read({pfx, "ien_l"},  BASE + 32'h0C, 32'h0);
    wb_read({pfx, "ien_h"},  BASE + 32'h10, 32'h0);
    wb_read({pfx, "stat_l"}, BASE + 32'h14, 32'h0);
    wb_read({pfx, "stat_h"}, BASE + 32'h18, 32'h0);
    check_eq({pfx, "irq"}, 64'(irq), 64'd0);
    wb_xfer(BASE + 32'h1C, 1'b0, 32'h0, 4'hF, r, ok);
    check_eq({pfx, "unmapped_noack"}, 64'(ok), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    logic [31:0] r;
    bit  ok;

    // 1: reset state
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mon_on = 1'b1;
    reset_reads("rst_");

    // 2: rising edge latency and irq
    io[3] = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (deb[3]) begin n = i; break; end
    end
    check_eq("lat_deb3", 64'(n), 64'd5);
    wb_read("stat_l_b3", BASE + 32'h14, 32'h8);
    wb_write("ien_l", BASE + 32'h0C, 32'h8, 4'hF);
    check_eq("irq_set", 64'(irq), 64'd1);
    wb_write("w1c", BASE + 32'h14, 32'h8, 4'hF);
    wb_read("stat_l_clr", BASE + 32'h14, 32'h0);
    check_eq("irq_clr", 64'(irq), 64'd0);

    // 3: short glitch filtered, then passed in bypass
    io[0] = 1'b1;
    repeat (2) @(negedge clk);
    io[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (deb[0]) seen = 1'b1; end
    check_eq("glitch_blocked", 64'(seen), 64'd0);
    wb_read("stat_l_glitch", BASE + 32'h14, 32'h0);
    wb_write("ctrl_byp", BASE + 32'h08, 32'h5, 4'hF);
    io[0] = 1'b1;
    repeat (2) @(negedge clk);
    io[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (deb[0]) seen = 1'b1; end
    check_eq("glitch_bypass", 64'(seen), 64'd1);
    wb_read("stat_l_byp", BASE + 32'h14, 32'h1);
    wb_write("ctrl_nobyp", BASE + 32'h08, 32'h1, 4'hF);
    wb_write("w1c_all", BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);

    // 4: fall only, div=3
    wb_write("ctrl_fall", BASE + 32'h08, 32'h0000_0302, 4'hF);
    wb_read("ctrl_rb", BASE + 32'h08, 32'h0000_0302);
    io[37] = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("deb37_high", 64'(deb[37]), 64'd1);
    wb_read("stat_h_rise", BASE + 32'h18, 32'h0);
    io[37] = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!deb[37]) begin n = i; break; end
    end
    check_eq("fall_lat_ok", 64'(n >= 1 && n <= 14), 64'd1);
    wb_read("stat_h_fall", BASE + 32'h18, 32'h20);
    wb_read("stat_l_fall", BASE + 32'h14, 32'h0);

    // 5: set coincident with W1C, and byte-lane write
    wb_write("ctrl_both", BASE + 32'h08, 32'h3, 4'hF);
    io[5] = 1'b1;
    repeat (4) @(negedge clk);
    wb_write("w1c_race", BASE + 32'h14, 32'h20, 4'hF);
    wb_read("stat_l_race", BASE + 32'h14, 32'h20);
    wb_write("ien_l_zero", BASE + 32'h0C, 32'h0, 4'hF);
    wb_write("ien_l_lane", BASE + 32'h0C, 32'hFFFF_FFFF, 4'b0010);
    wb_read("ien_l_lane_rb", BASE + 32'h0C, 32'h0000_FF00);
    wb_write("ien_h_wide", BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wb_read("ien_h_rb", BASE + 32'h10, 32'h3F);

    // 6: asynchronous reset during a read strobe
    io = 38'h2A_5555_AAAA;
    repeat (12) @(negedge clk);
    check_eq("deb_active", 64'(deb), 64'h2A_5555_AAAA);
    adr = BASE; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("arst_ack", 64'(ack), 64'd0);
    check_eq("arst_dat", 64'(rdat), 64'd0);
    check_eq("arst_deb", 64'(deb), 64'd0);
    check_eq("arst_irq", 64'(irq), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    io = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mon_on = 1'b1;
    reset_reads("rst2_");

    // Random traffic against the model
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(7, 0) == 0) io[$urandom_range(NPADS - 1, 0)] ^= 1'b1;
      if ($urandom_range(3, 0) == 0) begin
        int          ri;
        logic [31:0] d;
        ri = int'($urandom_range(7, 0));
        d  = $urandom;
        if (ri == 2) d[15:10] = '0;
        wb_xfer(BASE + 32'(ri * 4), bit'($urandom_range(1, 0)), d, 4'($urandom_range(15, 0)),
                r, ok);
        check_eq("rand_ack", 64'(ok), 64'(ri != 7));
      end else begin
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
